// File: rtl/calc_sequencer.sv
// Fetch/decode/execute controller for the 8-bit calculator datapath.
// Owns PC and IR, slices the instruction word and pulses the register-file write.
module calc_sequencer #(
    parameter int                   PC_W      = 11,
    parameter int                   INSTR_W   = 14,
    parameter logic [INSTR_W-1:0]   HALT_WORD = '1,
    parameter logic [PC_W-1:0]      PC_LAST   = '1,
    parameter int                   CNT_W     = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_step_mode,
    input  logic               i_step,
    input  logic [INSTR_W-1:0] i_instruction,
    output logic [PC_W-1:0]    o_pc_addr,
    output logic [1:0]         o_alu_ctrl,
    output logic [3:0]         o_addr_a,
    output logic [3:0]         o_addr_b,
    output logic [3:0]         o_addr_d,
    output logic               o_rf_we,
    output logic               o_busy,
    output logic               o_done,
    output logic [CNT_W-1:0]   o_instr_count
);

    // state  | meaning
    // IDLE   | after reset, waiting for start
    // FETCH  | latch instruction at pc into ir
    // DECODE | ir stable; halt word detected here
    // EXEC   | rf_we high, result written, pc/count advance
    // PAUSE  | single-step wait for step
    // HALT   | done; pc and count held until restart
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_PAUSE  = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [PC_W-1:0]      r_pc;
    logic [INSTR_W-1:0]   r_ir;
    logic [CNT_W-1:0]     r_cnt;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: w_next = (r_ir == HALT_WORD) ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (r_pc == PC_LAST)  w_next = S_HALT;
                else if (i_step_mode) w_next = S_PAUSE;
                else                  w_next = S_FETCH;
            end
            S_PAUSE:  if (i_step || !i_step_mode) w_next = S_FETCH;
            S_HALT:   if (i_start) w_next = S_FETCH;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (i_start) begin
                        r_pc  <= '0;
                        r_cnt <= '0;
                    end
                end
                S_FETCH: r_ir <= i_instruction;
                S_EXEC: begin
                    if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
                    // the last address halts in place rather than wrapping to 0
                    if (r_pc != PC_LAST) r_pc <= r_pc + PC_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_pc_addr     = r_pc;
    assign o_alu_ctrl    = r_ir[13:12];
    assign o_addr_a      = r_ir[11:8];
    assign o_addr_b      = r_ir[7:4];
    assign o_addr_d      = r_ir[3:0];
    assign o_rf_we       = (r_state == S_EXEC);
    assign o_busy        = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_EXEC);
    assign o_done        = (r_state == S_HALT);
    assign o_instr_count = r_cnt;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: default-size instance plus a short-program
// instance (PC_LAST=3, 2-bit counter) sharing one instruction memory model.
module tb_calc_sequencer;

    typedef struct packed {
        logic [10:0] pc;
        logic [13:0] ir;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, start1, start2, step_mode, step;
    logic [13:0] imem [0:2047];
    logic [13:0] instr1, instr2;

    logic [10:0] pc1, pc2;
    logic [1:0]  alu1, alu2;
    logic [3:0]  a1, b1, d1, a2, b2, d2;
    logic        we1, we2, busy1, busy2, done1, done2;
    logic [15:0] cnt1;
    logic [1:0]  cnt2;

    exp_t q1[$];
    exp_t q2[$];
    int   we_t1[$];
    int   t, n_vec, n_err, we_cnt2, pc0_we2, n_run;

    always #5 clk = ~clk;

    assign instr1 = imem[pc1];
    assign instr2 = imem[pc2];

    calc_sequencer dut1 (
        .i_clk(clk), .i_reset(rst_n), .i_start(start1), .i_step_mode(step_mode),
        .i_step(step), .i_instruction(instr1), .o_pc_addr(pc1), .o_alu_ctrl(alu1),
        .o_addr_a(a1), .o_addr_b(b1), .o_addr_d(d1), .o_rf_we(we1), .o_busy(busy1),
        .o_done(done1), .o_instr_count(cnt1)
    );

    calc_sequencer #(.PC_LAST(11'd3), .CNT_W(2)) dut2 (
        .i_clk(clk), .i_reset(rst_n), .i_start(start2), .i_step_mode(1'b0),
        .i_step(1'b0), .i_instruction(instr2), .o_pc_addr(pc2), .o_alu_ctrl(alu2),
        .o_addr_a(a2), .o_addr_b(b2), .o_addr_d(d2), .o_rf_we(we2), .o_busy(busy2),
        .o_done(done2), .o_instr_count(cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock; sample 1 time unit after the edge and score any write
    task automatic cyc();
        exp_t e;
        @(posedge clk);
        #1;
        t++;
        if (we1) begin
            we_t1.push_back(t);
            if (q1.size() == 0) chk("we1_unexpected", {31'b0, we1}, 32'd0);
            else begin
                e = q1.pop_front();
                chk("we1_pc", {21'b0, pc1}, {21'b0, e.pc});
                chk("we1_ir", {18'b0, alu1, a1, b1, d1}, {18'b0, e.ir});
            end
        end
        if (we2) begin
            we_cnt2++;
            if (pc2 == 11'd0) pc0_we2++;
            if (q2.size() == 0) chk("we2_unexpected", {31'b0, we2}, 32'd0);
            else begin
                e = q2.pop_front();
                chk("we2_pc", {21'b0, pc2}, {21'b0, e.pc});
                chk("we2_ir", {18'b0, alu2, a2, b2, d2}, {18'b0, e.ir});
            end
        end
    endtask

    task automatic wait_done(input int sel, input int bound);
        for (int i = 0; i < bound; i++) begin
            cyc();
            if ((sel == 1) ? done1 : done2) return;
        end
        chk("done_timeout", (sel == 1) ? {31'b0, done1} : {31'b0, done2}, 32'd1);
    endtask

    task automatic push_prog1();
        q1.push_back('{pc: 11'd0, ir: 14'h0123});
        q1.push_back('{pc: 11'd1, ir: 14'h1456});
    endtask

    task automatic start_run1();
        push_prog1();
        we_t1.delete();
        t = 0;
        start1 = 1'b1;
        cyc();
        start1 = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0; t = 0; we_cnt2 = 0; pc0_we2 = 0;
        rst_n = 1'b0; start1 = 1'b1; start2 = 1'b1; step_mode = 1'b0; step = 1'b0;
        for (int i = 0; i < 2048; i++) imem[i] = 14'h0000;
        imem[0] = 14'h0123; imem[1] = 14'h1456; imem[2] = 14'h3FFF;

        // reset held two cycles with start asserted
        cyc(); cyc();
        chk("rst_out1", {pc1, alu1, a1, b1, d1, we1, busy1, done1}, 32'd0);
        chk("rst_cnt1", {16'b0, cnt1}, 32'd0);
        chk("rst_out2", {cnt2, pc2, we2, busy2, done2}, 32'd0);
        start2 = 1'b0;
        rst_n  = 1'b1;

        // run mode: two instructions then halt word
        start_run1();
        chk("start_pc", {21'b0, pc1}, 32'd0);
        chk("start_busy", {31'b0, busy1}, 32'd1);
        wait_done(1, 40);
        chk("run_done_t", t, 32'd9);
        chk("run_we_n", we_t1.size(), 32'd2);
        if (we_t1.size() == 2) begin
            chk("run_we_t0", we_t1[0], 32'd3);
            chk("run_we_t1", we_t1[1], 32'd6);
        end
        chk("run_cnt", {16'b0, cnt1}, 32'd2);
        chk("run_pc", {21'b0, pc1}, 32'd2);
        chk("run_q_empty", q1.size(), 32'd0);
        cyc(); cyc();
        chk("halt_hold", {cnt1, pc1, we1, busy1, done1}, {16'd2, 11'd2, 3'b001});

        // restart from HALT reruns identically
        start_run1();
        chk("restart_pc_cnt", {cnt1, 5'b0, pc1}, 32'd0);
        chk("restart_busy_done", {busy1, done1}, 32'b10);
        wait_done(1, 40);
        chk("rerun_done_t", t, 32'd9);
        chk("rerun_we_n", we_t1.size(), 32'd2);
        if (we_t1.size() == 2) chk("rerun_we_t", {we_t1[0][15:0], we_t1[1][15:0]}, {16'd3, 16'd6});
        chk("rerun_cnt_pc", {cnt1, 5'b0, pc1}, {16'd2, 16'd2});

        // single-step mode
        step_mode = 1'b1;
        start_run1();
        cyc(); cyc();
        chk("step_we1", {31'b0, we1}, 32'd1);
        cyc();
        chk("pause1", {cnt1, pc1, we1, busy1, done1}, {16'd1, 11'd1, 3'b000});
        start1 = 1'b1;
        cyc(); cyc();
        start1 = 1'b0;
        chk("pause_ign_start", {cnt1, pc1, we1, busy1, done1}, {16'd1, 11'd1, 3'b000});
        step = 1'b1;
        cyc();
        step = 1'b0;
        chk("step_fetch", {pc1, busy1}, {11'd1, 1'b1});
        cyc(); cyc();
        chk("step_we2", {31'b0, we1}, 32'd1);
        cyc();
        chk("pause2", {cnt1, pc1, we1, busy1, done1}, {16'd2, 11'd2, 3'b000});
        step = 1'b1;
        cyc();
        step = 1'b0;
        cyc(); cyc();
        chk("step_halt", {cnt1, pc1, we1, busy1, done1}, {16'd2, 11'd2, 3'b001});
        chk("step_q_empty", q1.size(), 32'd0);
        step_mode = 1'b0;

        // reset during EXEC of the first instruction
        q1.push_back('{pc: 11'd0, ir: 14'h0123});
        t = 0;
        start1 = 1'b1;
        cyc();
        start1 = 1'b0;
        cyc(); cyc();
        chk("abort_exec", {31'b0, we1}, 32'd1);
        rst_n = 1'b0;
        cyc();
        chk("abort_out", {pc1, alu1, a1, b1, d1, we1, busy1, done1}, 32'd0);
        chk("abort_cnt", {16'b0, cnt1}, 32'd0);
        rst_n = 1'b1;
        q1.delete();
        cyc();
        chk("abort_idle", {we1, busy1, done1}, 32'd0);

        // last address halts without wrapping; 2-bit count saturates
        imem[0] = 14'h0001; imem[1] = 14'h1112; imem[2] = 14'h2223; imem[3] = 14'h3334;
        for (int i = 0; i < 4; i++) q2.push_back('{pc: 11'(i), ir: imem[i]});
        t = 0;
        start2 = 1'b1;
        cyc();
        start2 = 1'b0;
        wait_done(2, 60);
        chk("last_done_t", t, 32'd13);
        chk("last_we_n", we_cnt2, 32'd4);
        chk("last_pc", {21'b0, pc2}, 32'd3);
        chk("last_cnt_sat", {30'b0, cnt2}, 32'd3);
        cyc(); cyc(); cyc();
        chk("last_hold", {pc2, cnt2, we2, busy2, done2}, {11'd3, 2'd3, 3'b001});
        chk("last_pc0_we", pc0_we2, 32'd1);
        chk("last_q_empty", q2.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
